secuenciar_notas: RTL and testbench



---
 rtl/secuenciar_notas.sv | 95 +++++++++
 tb/tb_secuenciar_notas.sv | 123 ++++++++++++
 2 files changed

// File: rtl/secuenciar_notas.sv
// Music-box sequencer: plays a fixed 16-step melody from ROM as a square wave,
// with a silent gap at the end of every step and an endless loop.
module secuenciar_notas #(
    parameter int CLK_HZ      = 12_000_000,
    parameter int NOTE_CYCLES = 3_000_000,
    parameter int GAP_CYCLES  = 300_000
) (
    input  logic clk,
    input  logic rst,
    output logic square_wave_final
);

    localparam int HALF_C4 = CLK_HZ / (2 * 262);
    localparam int HALF_D4 = CLK_HZ / (2 * 294);
    localparam int HALF_E4 = CLK_HZ / (2 * 330);
    localparam int HALF_F4 = CLK_HZ / (2 * 349);
    localparam int HALF_G4 = CLK_HZ / (2 * 392);
    localparam int HALF_A4 = CLK_HZ / (2 * 440);
    localparam int HALF_B4 = CLK_HZ / (2 * 494);
    localparam int HALF_C5 = CLK_HZ / (2 * 523);

    // C4 is the lowest pitch, so its half-period sizes the tone counter.
    localparam int TONE_W = (HALF_C4 > 1) ? $clog2(HALF_C4) : 1;
    localparam int NOTE_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam int ACTIVE_CYCLES = NOTE_CYCLES - GAP_CYCLES;

    logic [3:0]        step;
    logic [3:0]        note;
    logic [NOTE_W-1:0] note_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] half_m1;
    logic              is_rest;
    logic              note_end;
    logic              active;

    always_comb begin
        case (step)
            4'd0, 4'd1, 4'd14:  note = 4'd1;
            4'd2, 4'd3, 4'd6:   note = 4'd5;
            4'd4, 4'd5:         note = 4'd6;
            4'd8, 4'd9:         note = 4'd4;
            4'd10, 4'd11:       note = 4'd3;
            4'd12, 4'd13:       note = 4'd2;
            default:            note = 4'd0;
        endcase
    end

    always_comb begin
        case (note)
            4'd1:    half_m1 = TONE_W'(HALF_C4 - 1);
            4'd2:    half_m1 = TONE_W'(HALF_D4 - 1);
            4'd3:    half_m1 = TONE_W'(HALF_E4 - 1);
            4'd4:    half_m1 = TONE_W'(HALF_F4 - 1);
            4'd5:    half_m1 = TONE_W'(HALF_G4 - 1);
            4'd6:    half_m1 = TONE_W'(HALF_A4 - 1);
            4'd7:    half_m1 = TONE_W'(HALF_B4 - 1);
            4'd8:    half_m1 = TONE_W'(HALF_C5 - 1);
            default: half_m1 = '0;
        endcase
    end

    assign is_rest  = (note == 4'd0) || (note > 4'd8);
    assign note_end = (note_cnt == NOTE_W'(NOTE_CYCLES - 1));
    // One extra bit so a zero-length gap (active span == NOTE_CYCLES) still compares correctly.
    assign active   = ({1'b0, note_cnt} < (NOTE_W + 1)'(ACTIVE_CYCLES)) && !is_rest;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            step              <= 4'd0;
            note_cnt          <= '0;
            tone_cnt          <= '0;
            square_wave_final <= 1'b0;
        end else if (note_end) begin
            note_cnt          <= '0;
            step              <= step + 4'd1;
            tone_cnt          <= '0;
            square_wave_final <= 1'b0;
        end else begin
            note_cnt <= note_cnt + NOTE_W'(1);
            if (active) begin
                if (tone_cnt == half_m1) begin
                    tone_cnt          <= '0;
                    square_wave_final <= ~square_wave_final;
                end else begin
                    tone_cnt <= tone_cnt + TONE_W'(1);
                end
            end else begin
                tone_cnt          <= '0;
                square_wave_final <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_secuenciar_notas.sv
// Bench for secuenciar_notas: compares every sampled cycle against a model that
// derives the output from the edge count since reset, plus randomized resets.
module tb_secuenciar_notas;

    localparam int CLK_HZ = 26200;
    localparam int N      = 1000;
    localparam int G      = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic square_wave_final;

    int errors = 0;
    int checks = 0;
    int k      = 0;
    int melody [16] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 0};

    always #5 clk = ~clk;

    secuenciar_notas #(
        .CLK_HZ     (CLK_HZ),
        .NOTE_CYCLES(N),
        .GAP_CYCLES (G)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .square_wave_final(square_wave_final)
    );

    function automatic int freq_of(input int code);
        case (code)
            1: return 262;
            2: return 294;
            3: return 330;
            4: return 349;
            5: return 392;
            6: return 440;
            7: return 494;
            8: return 523;
            default: return 0;
        endcase
    endfunction

    // Expected output after edge kk (kk = 0 means reset just applied).
    function automatic logic model(input int kk);
        int s, j, f, h;
        if (kk == 0) return 1'b0;
        s = ((kk - 1) / N) % 16;
        j = (kk - 1) % N + 1;
        f = freq_of(melody[s]);
        if (f == 0 || j > N - G || j == N) return 1'b0;
        h = CLK_HZ / (2 * f);
        return ((j / h) % 2) == 1;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0d, expected %0d", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else     k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("wave", int'(square_wave_final), int'(model(k)));
            case (k)
                49, 100, 1049, 2032, 7500, 950: chk("landmark_low", int'(square_wave_final), 0);
                50, 99, 1050, 2033, 16050:      chk("landmark_high", int'(square_wave_final), 1);
                default: ;
            endcase
        end
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("reset_low", int'(square_wave_final), 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        int edges;
        bit seen;

        hold_reset(5);
        // Two full melody periods: wrap must reproduce the first period exactly.
        run(32000);

        // Mid-note reset at the equivalent of k=2500, then measure the first rise.
        run(2499);
        hold_reset(1);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            edges++;
            chk("wave_after_rst", int'(square_wave_final), int'(model(k)));
            if (square_wave_final === 1'b1) seen = 1'b1;
        end
        chk("rise_after_rst", seen ? edges : -1, 50);

        for (int it = 0; it < 5; it++) begin
            run(int'($urandom_range(1, 6000)));
            hold_reset(int'($urandom_range(1, 3)));
        end
        run(1200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
